ccip_mmio_fifo_regs: RTL and testbench
======================================

// Module: ccip_mmio_fifo_regs
// PURPOSE
// - Parametrised MMIO register block for the ccip_mmio AFU. Decodes host MMIO reads/writes from CCI-P c0.
// - Answers the mandatory DFH/AFU_ID CSRs and provides a scratch register.
// - Provides a host-visible FIFO of DEPTH x DATA_W: push via MMIO write, pop via MMIO read.
// - Provides status/control CSRs with sticky error flags.
// - The afu top flattens rx.c0 (mmio_hdr address/tid, data) into the inputs below and packs tx.c2 from the outputs.
// PARAMETERS
// - DATA_W     64            FIFO entry width, 1..64. Writes keep data[DATA_W-1:0]; reads are zero-extended to 64.
// - DEPTH      8             FIFO entries, power of 2, 2..256.
// - BASE_ADDR  16'h0020      First user CSR address (32-bit-word units, even).
// - AFU_ID     128'h0        Value returned at 0x0002 (low half) and 0x0004 (high half).
// PORTS
// - clk           in   1    Single clock.
// - rst           in   1    Asynchronous reset, active-high.
// - mmio_wr_valid in   1    Host MMIO write strobe (rx.c0.mmioWrValid).
// - mmio_rd_valid in   1    Host MMIO read strobe (rx.c0.mmioRdValid).
// - mmio_addr     in   16   MMIO address (mmio_hdr.address).
// - mmio_tid      in   9    Read transaction ID (mmio_hdr.tid).
// - mmio_wr_data  in   64   Write data (rx.c0.data[63:0]).
// - rd_rsp_valid  out  1    Read response strobe (tx.c2.mmioRdValid).
// - rd_rsp_tid    out  9    Echoed TID (tx.c2.hdr.tid).
// - rd_rsp_data   out  64   Read data (tx.c2.data).
// BEHAVIOUR
// - Reset: rd_rsp_valid=0, rd_rsp_tid=0, rd_rsp_data=0, scratch=0, FIFO empty (rd/wr ptr=0, count=0), sticky flags=0.
// - Read latency exactly 1 cycle:
//   - mmio_rd_valid at cycle N -> rd_rsp_valid=1 for one cycle at N+1, with rd_rsp_tid=mmio_tid(N).
//   - rd_rsp_data holds its value when rd_rsp_valid=0.
// - Address map (reads; unlisted addresses return 0, writes to them ignored):
//   - 0x0000  DFH = {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0}.
//   - 0x0002  AFU_ID[63:0]; 0x0004 AFU_ID[127:64]; 0x0006/0x0008 = 0.
//   - BASE+0  SCRATCH: R/W 64b.
//   - BASE+2  FIFO_DATA:
//     - write pushes data; when full, data is dropped and OVF is set.
//     - read pops the head; when empty, returns 0, UNF is set, no pointer move.
//   - BASE+4  STATUS (RO): [8:0]=count (0..DEPTH), [32]=empty, [33]=full, [34]=OVF, [35]=UNF, others 0.
//   - BASE+6  CTRL (WO, reads 0): bit0=1 flushes (ptrs/count->0, data not cleared); bit1=1 clears OVF and UNF.
// - Pointers are log2(DEPTH) bits and wrap naturally. count is a separate log2(DEPTH)+1 bit counter.
// - Simultaneous mmio_wr_valid and mmio_rd_valid in one cycle: both are processed.
//   - Push+pop, 0<count<DEPTH: head returned, new data stored, count unchanged.
//   - Push+pop when full: both succeed, no OVF.
//   - Push+pop when empty: read returns 0 and sets UNF; push succeeds (no bypass), count=1.
//   - STATUS read in the same cycle as a push/pop returns the pre-update state.
//   - CTRL flush in the same cycle as a FIFO_DATA pop: the read returns the pre-flush head, then the FIFO is empty.
//   - CTRL clear in the same cycle as a new error event: the set wins.
// - Reset asserted mid-operation: state returns immediately to reset values, and a pending response is dropped.
// CONFIGURATION
// - MMIO_FIFO_PEEK_EN defined: BASE+8 PEEK (RO) returns the head entry without popping.
//   - PEEK when empty returns 0 and does NOT set UNF.
//   - STATUS[36]=1 advertises the feature.
// - MMIO_FIFO_PEEK_EN undefined: BASE+8 reads 0 and STATUS[36]=0; no peek logic is synthesised.
// TESTING
// - Reset, then read 0x0000 with tid=0x15 -> one cycle later: valid=1, tid=0x15, data=64'h1000_0100_0000_0000.
// - Write SCRATCH=64'hDEAD_BEEF_0123_4567, then read SCRATCH -> same value; read 0x0040 -> 0.
// - Push 1..8 (DEPTH=8) -> STATUS count=8, full=1.
//   - Push 9 -> OVF=1, count=8.
//   - Pop x8 -> returns 1..8 in order.
//   - 9th pop -> 0, UNF=1, empty=1.
// - Write CTRL=2 -> STATUS[35:34]=0. Then push 0xA, 0xB and write CTRL=1 -> count=0; pop -> 0, UNF=1.
// - Same cycle: push 0x5 with pop on empty -> rsp data 0, UNF=1, count=1.
//   - Next cycle: push 0x6 with pop -> returns 0x5, count=1.
// - PEEK_EN build: push 0x77, read PEEK twice -> 0x77 both times, count=1, STATUS[36]=1.
//   - Non-PEEK build: the same reads of BASE+8 -> 0.

Source files
------------

// File: rtl/ccip_mmio_fifo_regs.sv
// MMIO CSR block for the ccip_mmio AFU: DFH/AFU_ID, scratch, host-visible FIFO with status/control.
// Define MMIO_FIFO_PEEK_EN to add a non-popping PEEK CSR at BASE_ADDR+8.
module ccip_mmio_fifo_regs #(
  parameter int unsigned   DATA_W    = 64,
  parameter int unsigned   DEPTH     = 8,
  parameter logic [15:0]   BASE_ADDR = 16'h0020,
  parameter logic [127:0]  AFU_ID    = 128'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_wr_valid,
  input  logic        mmio_rd_valid,
  input  logic [15:0] mmio_addr,
  input  logic [8:0]  mmio_tid,
  input  logic [63:0] mmio_wr_data,
  output logic        rd_rsp_valid,
  output logic [8:0]  rd_rsp_tid,
  output logic [63:0] rd_rsp_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [15:0] ADDR_DFH     = 16'h0000;
  localparam logic [15:0] ADDR_ID_L    = 16'h0002;
  localparam logic [15:0] ADDR_ID_H    = 16'h0004;
  localparam logic [15:0] ADDR_SCRATCH = BASE_ADDR;
  localparam logic [15:0] ADDR_FIFO    = BASE_ADDR + 16'd2;
  localparam logic [15:0] ADDR_STATUS  = BASE_ADDR + 16'd4;
  localparam logic [15:0] ADDR_CTRL    = BASE_ADDR + 16'd6;
`ifdef MMIO_FIFO_PEEK_EN
  localparam logic [15:0] ADDR_PEEK    = BASE_ADDR + 16'd8;
  localparam logic        PEEK_EN      = 1'b1;
`else
  localparam logic        PEEK_EN      = 1'b0;
`endif

  localparam logic [63:0] DFH = {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0};
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic              rsp_valid_q, rsp_valid_d;
  logic [8:0]        rsp_tid_q, rsp_tid_d;
  logic [63:0]       rsp_data_q, rsp_data_d;
  logic [63:0]       scratch_q, scratch_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_fifo_c, rd_fifo_c, ctrl_wr_c;
  logic              empty_c, full_c, push_c, pop_c;
  logic [63:0]       head_c, status_c, rd_mux_c;

  // FIFO handshake decode; a pop frees a slot so push+pop on full both succeed
  always_comb begin
    wr_fifo_c = mmio_wr_valid && (mmio_addr == ADDR_FIFO);
    rd_fifo_c = mmio_rd_valid && (mmio_addr == ADDR_FIFO);
    ctrl_wr_c = mmio_wr_valid && (mmio_addr == ADDR_CTRL);
    empty_c   = (count_q == '0);
    full_c    = (count_q == FULL_CNT);
    pop_c     = rd_fifo_c && !empty_c;
    push_c    = wr_fifo_c && (!full_c || pop_c);
    head_c    = 64'(mem_q[rd_ptr_q]);
    status_c  = {27'b0, PEEK_EN, unf_q, ovf_q, full_c, empty_c, 23'b0, 9'(count_q)};
  end

  // Read data mux, always from pre-update state
  always_comb begin
    rd_mux_c = '0;
    case (mmio_addr)
      ADDR_DFH:     rd_mux_c = DFH;
      ADDR_ID_L:    rd_mux_c = AFU_ID[63:0];
      ADDR_ID_H:    rd_mux_c = AFU_ID[127:64];
      ADDR_SCRATCH: rd_mux_c = scratch_q;
      ADDR_FIFO:    rd_mux_c = empty_c ? 64'h0 : head_c;
      ADDR_STATUS:  rd_mux_c = status_c;
`ifdef MMIO_FIFO_PEEK_EN
      ADDR_PEEK:    rd_mux_c = empty_c ? 64'h0 : head_c;
`endif
      default:      rd_mux_c = '0;
    endcase
  end

  always_comb begin
    rsp_valid_d = mmio_rd_valid;
    rsp_tid_d   = rsp_tid_q;
    rsp_data_d  = rsp_data_q;
    scratch_d   = scratch_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    ovf_d       = ovf_q;
    unf_d       = unf_q;

    if (mmio_rd_valid) begin
      rsp_tid_d  = mmio_tid;
      rsp_data_d = rd_mux_c;
    end
    if (mmio_wr_valid && (mmio_addr == ADDR_SCRATCH)) scratch_d = mmio_wr_data;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    // Error set takes priority over a same-cycle clear
    if (ctrl_wr_c && mmio_wr_data[1]) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr_fifo_c && full_c && !pop_c) ovf_d = 1'b1;
    if (rd_fifo_c && empty_c)          unf_d = 1'b1;

    if (ctrl_wr_c && mmio_wr_data[0]) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
      scratch_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_tid_q   <= rsp_tid_d;
      rsp_data_q  <= rsp_data_d;
      scratch_q   <= scratch_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // Entry storage is not reset; flush only moves pointers
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= mmio_wr_data[DATA_W-1:0];
  end

  assign rd_rsp_valid = rsp_valid_q;
  assign rd_rsp_tid   = rsp_tid_q;
  assign rd_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ccip_mmio_fifo_regs.sv
// Directed bench for ccip_mmio_fifo_regs (DEPTH=8, BASE_ADDR=0x20); honours MMIO_FIFO_PEEK_EN.
module tb_ccip_mmio_fifo_regs;

  localparam logic [127:0] AFU_ID_P = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
  localparam logic [15:0] A_SCR  = 16'h0020;
  localparam logic [15:0] A_FIFO = 16'h0022;
  localparam logic [15:0] A_STAT = 16'h0024;
  localparam logic [15:0] A_CTRL = 16'h0026;
  localparam logic [15:0] A_PEEK = 16'h0028;
`ifdef MMIO_FIFO_PEEK_EN
  localparam logic [63:0] PK = 64'h10_0000_0000;
  localparam bit HAS_PEEK = 1'b1;
`else
  localparam logic [63:0] PK = 64'h0;
  localparam bit HAS_PEEK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mmio_wr_valid, mmio_rd_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wr_data;
  logic        rd_rsp_valid;
  logic [8:0]  rd_rsp_tid;
  logic [63:0] rd_rsp_data;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  ccip_mmio_fifo_regs #(
    .DATA_W(64), .DEPTH(8), .BASE_ADDR(16'h0020), .AFU_ID(AFU_ID_P)
  ) dut (
    .clk(clk), .rst(rst),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wr_data(mmio_wr_data),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_tid(rd_rsp_tid), .rd_rsp_data(rd_rsp_data)
  );

  always #5 clk = ~clk;

  // One bus cycle: drive at negedge, sample 1ns after the following posedge
  task automatic cyc(input logic wr, input logic rd, input logic [15:0] addr, input logic [8:0] tid,
                     input logic [63:0] wd, output logic v, output logic [8:0] t, output logic [63:0] d);
    @(negedge clk);
    mmio_wr_valid = wr; mmio_rd_valid = rd; mmio_addr = addr; mmio_tid = tid; mmio_wr_data = wd;
    @(posedge clk);
    #1;
    v = rd_rsp_valid; t = rd_rsp_tid; d = rd_rsp_data;
    mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [63:0] wd);
    logic v; logic [8:0] t; logic [63:0] d;
    cyc(1'b1, 1'b0, addr, 9'h0, wd, v, t, d);
  endtask

  task automatic rd(input logic [15:0] addr, output logic [63:0] d);
    logic v; logic [8:0] t;
    cyc(1'b0, 1'b1, addr, 9'h1A, 64'h0, v, t, d);
    if (v !== 1'b1) d = 64'hBAD0_BAD0_BAD0_BAD0;
  endtask

  task automatic test_reset();
    logic [63:0] d;
    rst = 1'b1; mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0;
    mmio_addr = '0; mmio_tid = '0; mmio_wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++; if ({rd_rsp_valid, rd_rsp_tid, rd_rsp_data} !== 74'h0) $display("FAIL reset_outputs: got v=%b tid=%h d=%h exp all zero", rd_rsp_valid, rd_rsp_tid, rd_rsp_data); else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    rd(A_STAT, d);
    chk_cnt++; if (d !== (64'h1_0000_0000 | PK)) $display("FAIL reset_status: got %h exp %h", d, 64'h1_0000_0000 | PK); else pass_cnt++;
    rd(A_SCR, d);
    chk_cnt++; if (d !== 64'h0) $display("FAIL reset_scratch: got %h exp 0", d); else pass_cnt++;
  endtask

  task automatic test_dfh();
    logic v; logic [8:0] t; logic [63:0] d;
    cyc(1'b0, 1'b1, 16'h0000, 9'h015, 64'h0, v, t, d);
    chk_cnt++; if ({v, t} !== {1'b1, 9'h015}) $display("FAIL dfh_rsp: got v=%b tid=%h exp v=1 tid=015", v, t); else pass_cnt++;
    chk_cnt++; if (d !== 64'h1000_0100_0000_0000) $display("FAIL dfh_data: got %h exp 1000010000000000", d); else pass_cnt++;
    cyc(1'b0, 1'b0, 16'h0000, 9'h0, 64'h0, v, t, d);
    chk_cnt++; if ({v, d} !== {1'b0, 64'h1000_0100_0000_0000}) $display("FAIL rsp_hold: got v=%b d=%h exp v=0 d held", v, d); else pass_cnt++;
    rd(16'h0002, d);
    chk_cnt++; if (d !== 64'h0F1E_2D3C_4B5A_6978) $display("FAIL afu_id_lo: got %h exp 0f1e2d3c4b5a6978", d); else pass_cnt++;
    rd(16'h0004, d);
    chk_cnt++; if (d !== 64'hFEDC_BA98_7654_3210) $display("FAIL afu_id_hi: got %h exp fedcba9876543210", d); else pass_cnt++;
    rd(16'h0006, d);
    chk_cnt++; if (d !== 64'h0) $display("FAIL rsvd_06: got %h exp 0", d); else pass_cnt++;
  endtask

  task automatic test_scratch();
    logic [63:0] d;
    wr(A_SCR, 64'hDEAD_BEEF_0123_4567);
    rd(A_SCR, d);
    chk_cnt++; if (d !== 64'hDEAD_BEEF_0123_4567) $display("FAIL scratch_rw: got %h exp deadbeef01234567", d); else pass_cnt++;
    wr(16'h0040, 64'h1234);
    rd(16'h0040, d);
    chk_cnt++; if (d !== 64'h0) $display("FAIL unmapped_40: got %h exp 0", d); else pass_cnt++;
    rd(A_CTRL, d);
    chk_cnt++; if (d !== 64'h0) $display("FAIL ctrl_reads_0: got %h exp 0", d); else pass_cnt++;
  endtask

  task automatic test_fifo_fill();
    logic [63:0] d;
    int errs;
    for (int i = 1; i <= 8; i++) wr(A_FIFO, 64'(i));
    rd(A_STAT, d);
    chk_cnt++; if (d !== (64'h2_0000_0008 | PK)) $display("FAIL full_status: got %h exp %h", d, 64'h2_0000_0008 | PK); else pass_cnt++;
    wr(A_FIFO, 64'd9);
    rd(A_STAT, d);
    chk_cnt++; if (d !== (64'h6_0000_0008 | PK)) $display("FAIL ovf_status: got %h exp %h", d, 64'h6_0000_0008 | PK); else pass_cnt++;
    errs = 0;
    for (int i = 1; i <= 8; i++) begin
      rd(A_FIFO, d);
      chk_cnt++; if (d !== 64'(i)) begin $display("FAIL pop_order[%0d]: got %h exp %h", i, d, 64'(i)); errs++; end else pass_cnt++;
    end
    rd(A_FIFO, d);
    chk_cnt++; if (d !== 64'h0) $display("FAIL pop_empty: got %h exp 0", d); else pass_cnt++;
    rd(A_STAT, d);
    chk_cnt++; if (d !== (64'hD_0000_0000 | PK)) $display("FAIL unf_status: got %h exp %h", d, 64'hD_0000_0000 | PK); else pass_cnt++;
  endtask

  task automatic test_ctrl();
    logic [63:0] d;
    wr(A_CTRL, 64'h2);
    rd(A_STAT, d);
    chk_cnt++; if (d !== (64'h1_0000_0000 | PK)) $display("FAIL ctrl_clear: got %h exp %h", d, 64'h1_0000_0000 | PK); else pass_cnt++;
    wr(A_FIFO, 64'hA);
    wr(A_FIFO, 64'hB);
    rd(A_STAT, d);
    chk_cnt++; if (d !== (64'h0_0000_0002 | PK)) $display("FAIL two_pushed: got %h exp %h", d, 64'h2 | PK); else pass_cnt++;
    wr(A_CTRL, 64'h1);
    rd(A_STAT, d);
    chk_cnt++; if (d !== (64'h1_0000_0000 | PK)) $display("FAIL flush_status: got %h exp %h", d, 64'h1_0000_0000 | PK); else pass_cnt++;
    rd(A_FIFO, d);
    chk_cnt++; if (d !== 64'h0) $display("FAIL pop_after_flush: got %h exp 0", d); else pass_cnt++;
    rd(A_STAT, d);
    chk_cnt++; if (d !== (64'h9_0000_0000 | PK)) $display("FAIL flush_unf: got %h exp %h", d, 64'h9_0000_0000 | PK); else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    logic v; logic [8:0] t; logic [63:0] d;
    wr(A_CTRL, 64'h3);
    cyc(1'b1, 1'b1, A_FIFO, 9'h033, 64'h5, v, t, d);
    chk_cnt++; if ({v, t, d} !== {1'b1, 9'h033, 64'h0}) $display("FAIL pushpop_empty: got v=%b tid=%h d=%h exp 1/033/0", v, t, d); else pass_cnt++;
    rd(A_STAT, d);
    chk_cnt++; if (d !== (64'h8_0000_0001 | PK)) $display("FAIL pushpop_empty_status: got %h exp %h", d, 64'h8_0000_0001 | PK); else pass_cnt++;
    cyc(1'b1, 1'b1, A_FIFO, 9'h034, 64'h6, v, t, d);
    chk_cnt++; if (d !== 64'h5) $display("FAIL pushpop_mid: got %h exp 5", d); else pass_cnt++;
    rd(A_STAT, d);
    chk_cnt++; if (d !== (64'h8_0000_0001 | PK)) $display("FAIL pushpop_mid_status: got %h exp %h", d, 64'h8_0000_0001 | PK); else pass_cnt++;
    rd(A_FIFO, d);
    chk_cnt++; if (d !== 64'h6) $display("FAIL pushpop_drain: got %h exp 6", d); else pass_cnt++;
  endtask

  task automatic test_back_to_back_full();
    logic v; logic [8:0] t; logic [63:0] d;
    wr(A_CTRL, 64'h3);
    for (int i = 0; i < 8; i++) wr(A_FIFO, 64'h100 + 64'(i));
    cyc(1'b1, 1'b1, A_FIFO, 9'h1FF, 64'h1FF, v, t, d);
    chk_cnt++; if ({v, t, d} !== {1'b1, 9'h1FF, 64'h100}) $display("FAIL pushpop_full: got v=%b tid=%h d=%h exp 1/1ff/100", v, t, d); else pass_cnt++;
    rd(A_STAT, d);
    chk_cnt++; if (d !== (64'h2_0000_0008 | PK)) $display("FAIL pushpop_full_status: got %h exp %h", d, 64'h2_0000_0008 | PK); else pass_cnt++;
    for (int i = 1; i < 8; i++) rd(A_FIFO, d);
    chk_cnt++; if (d !== 64'h107) $display("FAIL wrap_seventh: got %h exp 107", d); else pass_cnt++;
    rd(A_FIFO, d);
    chk_cnt++; if (d !== 64'h1FF) $display("FAIL wrap_last: got %h exp 1ff", d); else pass_cnt++;
  endtask

  task automatic test_peek();
    logic [63:0] d;
    wr(A_CTRL, 64'h3);
    wr(A_FIFO, 64'h77);
    rd(A_PEEK, d);
    chk_cnt++; if (d !== (HAS_PEEK ? 64'h77 : 64'h0)) $display("FAIL peek_first: got %h exp %h", d, HAS_PEEK ? 64'h77 : 64'h0); else pass_cnt++;
    rd(A_PEEK, d);
    chk_cnt++; if (d !== (HAS_PEEK ? 64'h77 : 64'h0)) $display("FAIL peek_second: got %h exp %h", d, HAS_PEEK ? 64'h77 : 64'h0); else pass_cnt++;
    rd(A_STAT, d);
    chk_cnt++; if (d !== (64'h0_0000_0001 | PK)) $display("FAIL peek_status: got %h exp %h", d, 64'h1 | PK); else pass_cnt++;
    wr(A_CTRL, 64'h1);
    rd(A_PEEK, d);
    chk_cnt++; if (d !== 64'h0) $display("FAIL peek_empty: got %h exp 0", d); else pass_cnt++;
    rd(A_STAT, d);
    chk_cnt++; if (d !== (64'h1_0000_0000 | PK)) $display("FAIL peek_empty_no_unf: got %h exp %h", d, 64'h1_0000_0000 | PK); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    wr(A_SCR, 64'h55);
    wr(A_FIFO, 64'h1);
    wr(A_FIFO, 64'h2);
    @(negedge clk);
    mmio_rd_valid = 1'b1; mmio_addr = A_SCR; mmio_tid = 9'h0AA;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk_cnt++; if ({rd_rsp_valid, rd_rsp_tid, rd_rsp_data} !== 74'h0) $display("FAIL reset_mid_rsp: got v=%b tid=%h d=%h exp all zero", rd_rsp_valid, rd_rsp_tid, rd_rsp_data); else pass_cnt++;
    mmio_rd_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    rd(A_STAT, d);
    chk_cnt++; if (d !== (64'h1_0000_0000 | PK)) $display("FAIL reset_mid_status: got %h exp %h", d, 64'h1_0000_0000 | PK); else pass_cnt++;
    rd(A_SCR, d);
    chk_cnt++; if (d !== 64'h0) $display("FAIL reset_mid_scratch: got %h exp 0", d); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_dfh();
    test_scratch();
    test_fifo_fill();
    test_ctrl();
    test_same_cycle();
    test_back_to_back_full();
    test_peek();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
